// File: rtl/simple_cpu_pkg.sv
// Shared definitions for simple_cpu and its instruction sequencer:
// opcode values, instruction field positions and sequencer state encoding.
package simple_cpu_pkg;

    localparam logic [1:0] OP_HALT  = 2'b00;
    localparam logic [1:0] OP_ALU   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;

    // Opcode field of the 20-bit simple_cpu instruction word
    localparam int unsigned OPC_HI = 19;
    localparam int unsigned OPC_LO = 18;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HOLD,
        ST_HALTED
    } state_t;

    function automatic logic is_halt(input logic [1:0] opc);
        return opc == OP_HALT;
    endfunction

endpackage

// File: rtl/instr_store.sv
// Program store: synchronous write port, combinational read port.
// Contents are deliberately not reset so a loaded program survives rst.
module instr_store #(
    parameter int unsigned WIDTH     = 20,
    parameter int unsigned ADDR_BITS = 5
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [ADDR_BITS-1:0] i_waddr,
    input  logic [WIDTH-1:0]     i_wdata,
    input  logic [ADDR_BITS-1:0] i_raddr,
    output logic [WIDTH-1:0]     o_rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port: one word per clock when enabled
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction source for simple_cpu: walks the program store with a PC and
// holds each issued word on the instruction output for HOLD_CYCLES+1 clocks.
module instr_sequencer
    import simple_cpu_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH = 20,
    parameter int unsigned PC_BITS     = 5,
    parameter int unsigned HOLD_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   prog_we,
    input  logic [PC_BITS-1:0]     prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    input  logic                   start,
    input  logic [PC_BITS-1:0]     start_pc,
    input  logic                   abort,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [PC_BITS-1:0]     pc,
    output logic                   issue,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned        CNT_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [PC_BITS-1:0] PC_LAST  = '1;

    state_t                 r_state, w_state_nxt;
    logic [PC_BITS-1:0]     r_pc, w_pc_nxt;
    logic [INSTR_WIDTH-1:0] r_instr, w_instr_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
    logic                   r_issue, w_issue_nxt;
    logic                   w_we;
    logic [INSTR_WIDTH-1:0] w_rd_data;

    // Store is writable only while no program is running
    assign w_we = prog_we && ((r_state == ST_IDLE) || (r_state == ST_HALTED));

    instr_store #(
        .WIDTH     (INSTR_WIDTH),
        .ADDR_BITS (PC_BITS)
    ) u_store (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (prog_addr),
        .i_wdata (prog_data),
        .i_raddr (r_pc),
        .o_rdata (w_rd_data)
    );

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_instr <= '0;
            r_cnt   <= '0;
            r_issue <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_issue <= w_issue_nxt;
        end
    end

    // Next-state logic; abort takes priority over start everywhere
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_cnt_nxt   = r_cnt;
        w_issue_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_pc_nxt    = start_pc;
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (is_halt(w_rd_data[OPC_HI:OPC_LO])) begin
                    w_state_nxt = ST_HALTED;
                end else begin
                    w_instr_nxt = w_rd_data;
                    w_issue_nxt = 1'b1;
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == '0) begin
                    if (r_pc == PC_LAST) begin
                        w_state_nxt = ST_HALTED;
                    end else begin
                        w_pc_nxt    = r_pc + 1'b1;
                        w_state_nxt = ST_FETCH;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_HALTED: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (start) begin
                    w_pc_nxt    = start_pc;
                    w_state_nxt = ST_FETCH;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign instruction = r_instr;
    assign pc          = r_pc;
    assign issue       = r_issue;
    assign busy        = (r_state == ST_FETCH) || (r_state == ST_HOLD);
    assign done        = (r_state == ST_HALTED);

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: table of runs with expected issue count, final
// pc and start-to-done latency; issued words checked against a scoreboard.
module tb_instr_sequencer;
    import simple_cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_we;
    logic [4:0]  prog_addr;
    logic [19:0] prog_data;
    logic        start;
    logic [4:0]  start_pc;
    logic        abort;
    logic [19:0] instruction;
    logic [4:0]  pc;
    logic        issue;
    logic        busy;
    logic        done;

    instr_sequencer #(
        .INSTR_WIDTH (20),
        .PC_BITS     (5),
        .HOLD_CYCLES (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .start       (start),
        .start_pc    (start_pc),
        .abort       (abort),
        .instruction (instruction),
        .pc          (pc),
        .issue       (issue),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  pc;
        logic [19:0] w;
    } exp_t;

    // mode: 0 plain run, 1 prog_we/start during HOLD, 2 abort in HOLD, 3 async reset in HOLD
    typedef struct {
        int spc;
        int exp_n;
        int exp_pc;
        int exp_lat;
        int mode;
    } vec_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [19:0] shadow [32];
    int          n_pass = 0;
    int          n_total = 0;
    int          n_issue = 0;
    int          hold_bad = 0;
    int          cyc = 0;
    int          last_issue = -1;
    logic        have_word = 1'b0;
    logic [19:0] last_word = '0;

    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Scoreboard consumer: every issue pulse must match the next expected word
    always @(negedge clk) begin
        if (!rst && issue) begin
            n_issue++;
            if (exp_q.size() == 0) begin
                check("unexpected_issue", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("issue_pc", 32'(pc), 32'(e.pc));
                check("issue_word", 32'(instruction), 32'(e.w));
            end
            if (last_issue >= 0) check("issue_spacing", 32'(cyc - last_issue), 32'd4);
            last_issue = cyc;
            last_word  = instruction;
            have_word  = 1'b1;
        end else if (!rst && busy && have_word && (instruction !== last_word)) begin
            hold_bad++;
        end
    end

    function automatic void model_push(input int spc, input int maxn);
        int p = spc;
        int n = 0;
        while (n < maxn && shadow[p][19:18] != OP_HALT) begin
            exp_q.push_back({p[4:0], shadow[p]});
            n++;
            if (p == 31) break;
            p++;
        end
    endfunction

    task automatic write_word(input int a, input logic [19:0] d);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = a[4:0]; prog_data = d;
        shadow[a] = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic run(input int idx, input vec_t v);
        int lat = -1;
        n_issue = 0; last_issue = -1; have_word = 1'b0; hold_bad = 0;
        model_push(v.spc, (v.mode >= 2) ? 1 : 99);
        @(negedge clk);
        start = 1'b1; start_pc = v.spc[4:0];
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (v.mode == 1 && k == 3) begin
                prog_we = 1'b1; prog_addr = 5'd1; prog_data = '0;
                start = 1'b1; start_pc = 5'd5;
            end
            if (v.mode == 1 && k == 4) prog_we = 1'b0;
            if (v.mode == 2 && k == 3) abort = 1'b1;
            if (v.mode == 2 && k == 4) begin
                abort = 1'b0;
                check($sformatf("run%0d_abort_busy", idx), 32'(busy), 32'd0);
                check($sformatf("run%0d_abort_done", idx), 32'(done), 32'd0);
                check($sformatf("run%0d_abort_pc", idx), 32'(pc), 32'(v.spc));
                check($sformatf("run%0d_abort_instr", idx), 32'(instruction), 32'(shadow[v.spc]));
                break;
            end
            if (v.mode == 3 && k == 3) begin
                #2 rst = 1'b1;
                #1;
                check($sformatf("run%0d_rst_instr", idx), 32'(instruction), 32'd0);
                check($sformatf("run%0d_rst_pc", idx), 32'(pc), 32'd0);
                check($sformatf("run%0d_rst_busy", idx), 32'(busy), 32'd0);
                check($sformatf("run%0d_rst_issue", idx), 32'(issue), 32'd0);
                @(negedge clk);
                rst = 1'b0;
                break;
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        if (v.mode <= 1) begin
            check($sformatf("run%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
            check($sformatf("run%0d_final_pc", idx), 32'(pc), 32'(v.exp_pc));
            check($sformatf("run%0d_hold_stable", idx), 32'(hold_bad), 32'd0);
        end
        check($sformatf("run%0d_issue_count", idx), 32'(n_issue), 32'(v.exp_n));
        check($sformatf("run%0d_queue_empty", idx), 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    vec_t vecs[10];
    vec_t v30;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        start = 1'b0; start_pc = '0; abort = 1'b0;

        vecs[0] = '{spc: 0, exp_n: 3, exp_pc: 3, exp_lat: 14, mode: 0};
        vecs[1] = '{spc: 4, exp_n: 3, exp_pc: 7, exp_lat: 14, mode: 0};
        vecs[2] = '{spc: 2, exp_n: 1, exp_pc: 3, exp_lat: 6,  mode: 0};
        vecs[3] = '{spc: 3, exp_n: 0, exp_pc: 3, exp_lat: 2,  mode: 0};
        vecs[4] = '{spc: 0, exp_n: 3, exp_pc: 3, exp_lat: 14, mode: 1};
        vecs[5] = '{spc: 0, exp_n: 3, exp_pc: 3, exp_lat: 14, mode: 0};
        vecs[6] = '{spc: 0, exp_n: 1, exp_pc: 0, exp_lat: 0,  mode: 2};
        vecs[7] = '{spc: 2, exp_n: 1, exp_pc: 3, exp_lat: 6,  mode: 0};
        vecs[8] = '{spc: 0, exp_n: 1, exp_pc: 0, exp_lat: 0,  mode: 3};
        vecs[9] = '{spc: 0, exp_n: 3, exp_pc: 3, exp_lat: 14, mode: 0};

        #12;
        check("reset_instr", 32'(instruction), 32'd0);
        check("reset_pc", 32'(pc), 32'd0);
        check("reset_issue", 32'(issue), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        write_word(0, 20'b01000111000000000000);
        write_word(1, 20'b01010011000000000000);
        write_word(2, 20'b01110010000000000001);
        write_word(3, 20'b00000000000000000000);
        write_word(4, 20'b11011000000011110000);
        write_word(5, 20'b11001100000101100000);
        write_word(6, 20'b10111000000011110000);
        write_word(7, 20'b00000000000000000000);

        for (int i = 0; i < 10; i++) run(i, vecs[i]);

        // Fill the whole store with executable words; run must stop at the top address
        for (int a = 0; a < 32; a++) write_word(a, {OP_ALU, 18'(a)});
        v30 = '{spc: 30, exp_n: 2, exp_pc: 31, exp_lat: 9, mode: 0};
        run(10, v30);
        repeat (8) @(negedge clk);
        check("top_pc_no_wrap", 32'(pc), 32'd31);
        check("top_done_held", 32'(done), 32'd1);
        check("top_busy", 32'(busy), 32'd0);

        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check("halted_abort_done", 32'(done), 32'd0);
        check("halted_abort_busy", 32'(busy), 32'd0);

        // Write and start in the same IDLE clock: fetch must see the new HALT word
        n_issue = 0;
        @(negedge clk);
        prog_we = 1'b1; prog_addr = 5'd29; prog_data = '0; shadow[29] = '0;
        start = 1'b1; start_pc = 5'd29;
        @(negedge clk);
        prog_we = 1'b0; start = 1'b0;
        @(negedge clk);
        check("wr_start_done", 32'(done), 32'd1);
        check("wr_start_pc", 32'(pc), 32'd29);
        check("wr_start_no_issue", 32'(n_issue), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
